// File: rtl/pic_ctrl.sv
// Programmable interrupt controller: latches device request edges, arbitrates enabled
// pending sources by priority and presents the winner to the vector entry/return sequencer.
module pic_ctrl #(
    parameter int NUM_SRC   = 8,
    parameter int VECT_BASE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] dev_req,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_idx,
    input  logic [2:0]         cfg_pri,
    input  logic               cfg_en,
    input  logic [2:0]         curr_pri,
    input  logic               pic_ack,
    output logic [7:0]         pic_out,
    output logic [NUM_SRC-1:0] dev_ack,
    output logic               pend_any
);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        HOLD
    } state_t;

    state_t             state_q;
    logic [NUM_SRC-1:0] reqPrev_q;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] en_q;
    logic [NUM_SRC-1:0] devAck_q;
    logic [2:0]         pri_q [NUM_SRC];
    logic [2:0]         sel_q;
    logic [7:0]         picOut_q;

    logic               winFound;
    logic [2:0]         winPri;
    logic [2:0]         winIdx;
    logic               eligible;
    logic [3:0]         winVect;
    logic [NUM_SRC-1:0] selOneHot;
    logic               retire;
    logic [NUM_SRC-1:0] pend_d;

    // Strict '>' keeps the lowest index on a priority tie.
    always_comb begin
        winFound = 1'b0;
        winPri   = 3'd0;
        winIdx   = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend_q[i] && en_q[i] && (!winFound || (pri_q[i] > winPri))) begin
                winFound = 1'b1;
                winPri   = pri_q[i];
                winIdx   = 3'(i);
            end
        end
    end

    assign eligible = winFound && (winPri > curr_pri);
    assign winVect  = 4'(VECT_BASE + int'(winIdx));

    always_comb begin
        selOneHot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_q == 3'(i)) begin
                selOneHot[i] = 1'b1;
            end
        end
    end

    // A new request edge on the retiring source survives the retirement.
    assign retire = (state_q == PRESENT) && pic_ack;
    assign pend_d = (pend_q & ~(retire ? selOneHot : '0)) | (dev_req & ~reqPrev_q & en_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            reqPrev_q <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            devAck_q  <= '0;
            sel_q     <= 3'd0;
            picOut_q  <= 8'h00;
            for (int i = 0; i < NUM_SRC; i++) begin
                pri_q[i] <= 3'd0;
            end
        end else begin
            reqPrev_q <= dev_req;
            pend_q    <= pend_d;
            devAck_q  <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cfg_we && (cfg_idx == 3'(i))) begin
                    pri_q[i] <= cfg_pri;
                    en_q[i]  <= cfg_en;
                end
            end
            case (state_q)
                IDLE: begin
                    if (eligible) begin
                        picOut_q <= {1'b1, winPri, winVect};
                        sel_q    <= winIdx;
                        state_q  <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (pic_ack) begin
                        devAck_q    <= selOneHot;
                        picOut_q[7] <= 1'b0;
                        state_q     <= HOLD;
                    end else if (curr_pri >= picOut_q[6:4]) begin
                        picOut_q[7] <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                HOLD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pic_out  = picOut_q;
    assign dev_ack  = devAck_q;
    assign pend_any = |pend_q;

endmodule

// File: tb/tb_pic_ctrl.sv
// Directed bench for pic_ctrl: a table of single-source presentations plus
// hand-written sequences for arbitration, masking, ack/edge collision and reset.
module tb_pic_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dev_req;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [2:0] cfg_pri;
    logic       cfg_en;
    logic [2:0] curr_pri;
    logic       pic_ack;
    logic [7:0] pic_out;
    logic [7:0] dev_ack;
    logic       pend_any;

    int passCount = 0;
    int checkCount = 0;

    typedef struct {
        int         idx;
        logic [2:0] pri;
        logic [2:0] curr;
        logic [7:0] expOut;
    } vec_t;

    vec_t vecs [3];

    pic_ctrl #(.NUM_SRC(8), .VECT_BASE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .dev_req  (dev_req),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_pri  (cfg_pri),
        .cfg_en   (cfg_en),
        .curr_pri (curr_pri),
        .pic_ack  (pic_ack),
        .pic_out  (pic_out),
        .dev_ack  (dev_ack),
        .pend_any (pend_any)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
        end
    endtask

    task automatic cfgWrite(input int idx, input logic [2:0] pri, input logic en);
        cfg_we  = 1'b1;
        cfg_idx = 3'(idx);
        cfg_pri = pri;
        cfg_en  = en;
        tick();
        cfg_we  = 1'b0;
    endtask

    // Ack the presented vector, check the dev_ack pulse and the HOLD cycle.
    task automatic ackAndHold(input string name, input logic [7:0] expAck);
        pic_ack = 1'b1;
        tick();
        pic_ack = 1'b0;
        checkOutput({name, " dev_ack pulse"}, dev_ack, expAck);
        checkOutput({name, " valid drop"}, {7'd0, pic_out[7]}, 8'h00);
        tick();
        checkOutput({name, " dev_ack single"}, dev_ack, 8'h00);
        checkOutput({name, " hold no valid"}, {7'd0, pic_out[7]}, 8'h00);
    endtask

    task automatic applyStimulus();
        for (int v = 0; v < 3; v++) begin
            cfgWrite(vecs[v].idx, vecs[v].pri, 1'b1);
            curr_pri = vecs[v].curr;
            dev_req[vecs[v].idx] = 1'b1;
            tick();
            checkOutput($sformatf("vec%0d not yet valid", v), {7'd0, pic_out[7]}, 8'h00);
            tick();
            checkOutput($sformatf("vec%0d pic_out", v), pic_out, vecs[v].expOut);
            ackAndHold($sformatf("vec%0d", v), 8'(1 << vecs[v].idx));
            checkOutput($sformatf("vec%0d pend retired", v), {7'd0, pend_any}, 8'h00);
            dev_req[vecs[v].idx] = 1'b0;
            cfgWrite(vecs[v].idx, 3'd0, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{idx: 2, pri: 3'd5, curr: 3'd2, expOut: 8'hDA};
        vecs[1] = '{idx: 7, pri: 3'd7, curr: 3'd0, expOut: 8'hFF};
        vecs[2] = '{idx: 0, pri: 3'd1, curr: 3'd0, expOut: 8'h98};

        rst = 1'b1; dev_req = 8'hFF; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_pri = 3'd0;
        cfg_en = 1'b0; curr_pri = 3'd0; pic_ack = 1'b0;

        // Reset with all requests high; disabled edges after release must be dropped.
        tick(); tick();
        checkOutput("reset pic_out", pic_out, 8'h00);
        checkOutput("reset dev_ack", dev_ack, 8'h00);
        checkOutput("reset pend_any", {7'd0, pend_any}, 8'h00);
        rst = 1'b0;
        tick(); tick(); tick();
        checkOutput("post-reset pic_out", pic_out, 8'h00);
        checkOutput("post-reset pend_any", {7'd0, pend_any}, 8'h00);
        dev_req = 8'h00;
        tick();

        applyStimulus();

        // Arbitration: tie at pri 4 goes to lowest index, then the lower priority.
        cfgWrite(1, 3'd4, 1'b1);
        cfgWrite(6, 3'd4, 1'b1);
        cfgWrite(3, 3'd3, 1'b1);
        curr_pri = 3'd0;
        dev_req = 8'b0100_1010;
        tick(); tick();
        checkOutput("arb first src1", pic_out, 8'hC9);
        ackAndHold("arb src1", 8'h02);
        tick();
        checkOutput("arb second src6", pic_out, 8'hCE);
        ackAndHold("arb src6", 8'h40);
        tick();
        checkOutput("arb third src3", pic_out, 8'hBB);
        ackAndHold("arb src3", 8'h08);
        checkOutput("arb all retired", {7'd0, pend_any}, 8'h00);
        dev_req = 8'h00;
        cfgWrite(1, 3'd0, 1'b0);
        cfgWrite(6, 3'd0, 1'b0);
        cfgWrite(3, 3'd0, 1'b0);

        // Masking by curr_pri, then withdraw while presenting.
        cfgWrite(0, 3'd3, 1'b1);
        curr_pri = 3'd3;
        dev_req[0] = 1'b1;
        tick(); tick(); tick();
        checkOutput("mask equal pri no valid", {7'd0, pic_out[7]}, 8'h00);
        checkOutput("mask pend_any", {7'd0, pend_any}, 8'h01);
        curr_pri = 3'd2;
        tick();
        checkOutput("mask unmasked present", pic_out, 8'hB8);
        curr_pri = 3'd6;
        tick();
        checkOutput("withdraw pic_out", pic_out, 8'h38);
        checkOutput("withdraw pend kept", {7'd0, pend_any}, 8'h01);
        checkOutput("withdraw no dev_ack", dev_ack, 8'h00);
        tick();
        checkOutput("withdraw stays idle", {7'd0, pic_out[7]}, 8'h00);
        curr_pri = 3'd2;
        tick();
        checkOutput("re-present after withdraw", pic_out, 8'hB8);
        curr_pri = 3'd0;
        ackAndHold("mask cleanup", 8'h01);
        dev_req[0] = 1'b0;
        cfgWrite(0, 3'd0, 1'b0);

        // New edge on the selected source in the ack cycle: set wins over clear.
        cfgWrite(5, 3'd2, 1'b1);
        dev_req[5] = 1'b1;
        tick(); tick();
        checkOutput("simul present", pic_out, 8'hAD);
        dev_req[5] = 1'b0;
        tick();
        checkOutput("simul held stable", pic_out, 8'hAD);
        dev_req[5] = 1'b1;
        pic_ack = 1'b1;
        tick();
        pic_ack = 1'b0;
        checkOutput("simul dev_ack", dev_ack, 8'h20);
        checkOutput("simul pend kept", {7'd0, pend_any}, 8'h01);
        checkOutput("simul valid drop", {7'd0, pic_out[7]}, 8'h00);
        tick();
        checkOutput("simul hold no valid", {7'd0, pic_out[7]}, 8'h00);
        tick();
        checkOutput("simul re-present", pic_out, 8'hAD);
        ackAndHold("simul cleanup", 8'h20);
        checkOutput("simul retired", {7'd0, pend_any}, 8'h00);
        pic_ack = 1'b1;
        tick();
        pic_ack = 1'b0;
        checkOutput("idle ack no dev_ack", dev_ack, 8'h00);
        checkOutput("idle ack no valid", {7'd0, pic_out[7]}, 8'h00);
        dev_req[5] = 1'b0;
        cfgWrite(5, 3'd0, 1'b0);

        // Reset while presenting, with a concurrent ack that must not pulse dev_ack.
        cfgWrite(4, 3'd6, 1'b1);
        dev_req[4] = 1'b1;
        tick(); tick();
        checkOutput("midreset present", pic_out, 8'hEC);
        rst = 1'b1;
        pic_ack = 1'b1;
        tick();
        rst = 1'b0;
        pic_ack = 1'b0;
        checkOutput("midreset pic_out", pic_out, 8'h00);
        checkOutput("midreset dev_ack", dev_ack, 8'h00);
        checkOutput("midreset pend_any", {7'd0, pend_any}, 8'h00);
        tick(); tick();
        checkOutput("midreset enables cleared", pic_out, 8'h00);
        checkOutput("midreset no late dev_ack", dev_ack, 8'h00);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
